hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- REGW, 4, register-index width.
- CNTW, 16, performance-counter width.
- FWD_EN, 1, forwarding enable (0 = stall-only mode).
- TIMEOUT, 255, maximum memory-wait cycles before error.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock.
- reset, in, 1, asynchronous active-low reset.
- RA1D/RA2D/RA1E/RA2E, in, REGW, source registers in Decode/Execute.
- WA3E/WA3M/WA3W, in, REGW, destination registers.
- RegWriteE/RegWriteM/RegWriteW, in, 1, write enables.
- MemtoRegE, in, 1, load in Execute.
- PCWriteD, in, 1, Decode instruction writes R15 non-branch.
- BranchTakenE, in, 1, branch resolved taken.
- MemReqM/MemReadyM, in, 1, data-memory request and ready.
- CntClear, in, 1, synchronous counter clear.
- ForwardAE/ForwardBE, out, 2, operand select.
- StallF/StallD/StallE/StallM, out, 1, stage holds.
- FlushD/FlushE/FlushW, out, 1, stage bubbles.
- PCWrPendingF, out, 1, PC write in flight.
- MemErr, out, 1, sticky wait-timeout flag.
- StallCnt/FlushCnt, out, CNTW, performance counters.

Function
REQ-003 ForwardXE SHALL be 2'b10 when RegWriteM & WA3M==RAxE, else 2'b01 when RegWriteW & WA3W==RAxE, else 2'b00; M has priority; R15 (all ones) is never forwarded.
REQ-004 With FWD_EN=0, ForwardXE SHALL be 2'b00 and a Decode RAW match against any of E/M/W with its RegWrite set SHALL raise rawStall.
REQ-005 ldStall SHALL be MemtoRegE & (WA3E==RA1D | WA3E==RA2D).
REQ-006 Internal flags pcwE/pcwM/pcwW SHALL track PCWriteD down the pipe: pcwE loads PCWriteD when !StallE, clears when FlushE; pcwM loads pcwE when !StallM; pcwW loads pcwM, clears when FlushW.
REQ-007 PCWrPendingF SHALL equal PCWriteD | pcwE | pcwM.
REQ-008 Normal case:
- StallF = ldStall | rawStall | PCWrPendingF.
- StallD = ldStall | rawStall.
- FlushE = ldStall | rawStall | BranchTakenE.
- FlushD = PCWrPendingF | pcwW | BranchTakenE.
- StallE = StallM = FlushW = 0.
REQ-009 BranchTakenE SHALL override ldStall/rawStall: StallF=StallD=0, FlushD=FlushE=1.
REQ-010 FSM states SHALL be RUN and WAIT:
- RUN->WAIT on MemReqM & !MemReadyM.
- WAIT->RUN on MemReadyM.
- A 0..TIMEOUT wait counter increments in WAIT and clears on entering RUN.
REQ-011 memStall = MemReqM & !MemReadyM SHALL override all other terms:
- StallF/D/E/M = 1.
- FlushD = FlushE = 0.
- FlushW = 1.
- A pending branch is held and acted on once the stall is released.
REQ-012 MemErr SHALL set when the wait counter reaches TIMEOUT and remain set until reset; the pipeline stays stalled.
REQ-013 StallCnt SHALL increment on every cycle with StallF=1, and FlushCnt on every cycle with FlushE=1; both saturate at all ones.
REQ-014 CntClear SHALL zero both counters synchronously, taking priority over increment.

Reset
REQ-015 reset low SHALL asynchronously force FSM=RUN, wait counter=0, pcwE/M/W=0, MemErr=0, StallCnt=FlushCnt=0; all other outputs are combinational from inputs and state.
REQ-016 Reset asserted mid-WAIT SHALL return to RUN with no pending PC-write state retained.

Structure
REQ-017 Package hazard_pkg SHALL hold:
- fwd_sel_t (FWD_RF=00, FWD_W=01, FWD_M=10).
- state_t (RUN, WAIT).
- Constant PC_IDX = all-ones register index.
REQ-018 One sub-module, sat_counter (CNTW-bit saturating counter with clear/enable), SHALL be instantiated twice.

Verification
REQ-019 RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3 -> ForwardAE=10; with RA1E=15 and WA3M=15 -> ForwardAE=00.
REQ-020 MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for one cycle; adding BranchTakenE=1 -> StallF=0, FlushD=FlushE=1.
REQ-021 PCWriteD pulse, no stalls -> PCWrPendingF high for 3 cycles, FlushD high for 4 cycles.
REQ-022 MemReqM=1, MemReadyM=0 for 3 cycles -> all stalls and FlushW=1 for those cycles, StallCnt increments by 3; ready -> RUN, outputs normal next cycle.
REQ-023 TIMEOUT=4, MemReadyM held 0 -> MemErr rises on the 5th WAIT cycle and stays high after ready; reset low -> MemErr=0, counters=0.
REQ-024 FWD_EN=0, RegWriteW=1, WA3W=2, RA1D=2 -> StallD=1, ForwardAE=00; StallCnt saturates at all ones; CntClear -> 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Operand source select for the Execute-stage ALU inputs
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,  // register file value read in Decode
    FWD_W  = 2'b01,  // result in Writeback
    FWD_M  = 2'b10   // ALU result in Memory
  } fwd_sel_t;

  // Memory-wait controller states
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Widest register index supported; the PC is always the all-ones index
  localparam int                    MAX_REGW = 32;
  localparam logic [MAX_REGW-1:0]   PC_IDX   = '1;

  // Memory-stage result is the younger producer, so it wins over Writeback
  function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
    if (hit_m) return FWD_M;
    if (hit_w) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all ones; clear wins over count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, hold at all ones, zero on clear
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load/RAW stalls, PC-write and branch flushes,
// memory-wait stalls with a sticky timeout flag, and stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REGW    = 4,
  parameter int CNTW    = 16,
  parameter int FWD_EN  = 1,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] RA1D,
  input  logic [REGW-1:0] RA2D,
  input  logic [REGW-1:0] RA1E,
  input  logic [REGW-1:0] RA2E,
  input  logic [REGW-1:0] WA3E,
  input  logic [REGW-1:0] WA3M,
  input  logic [REGW-1:0] WA3W,
  input  logic            RegWriteE,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic            MemtoRegE,
  input  logic            PCWriteD,
  input  logic            BranchTakenE,
  input  logic            MemReqM,
  input  logic            MemReadyM,
  input  logic            CntClear,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            StallM,
  output logic            FlushD,
  output logic            FlushE,
  output logic            FlushW,
  output logic            PCWrPendingF,
  output logic            MemErr,
  output logic [CNTW-1:0] StallCnt,
  output logic [CNTW-1:0] FlushCnt
);

  localparam logic [REGW-1:0]  PC_REG   = PC_IDX[REGW-1:0];
  localparam int               WAITW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAITW-1:0] WAIT_MAX = WAITW'(TIMEOUT);
  localparam logic [0:0]       S_RUN    = RUN;
  localparam logic [0:0]       S_WAIT   = WAIT;

  logic [0:0]       state_q, state_d;
  logic [WAITW-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q;
  logic             pcw_e_q, pcw_m_q, pcw_w_q;
  logic             ld_stall, raw_stall, mem_stall;
  logic             raw_hit_1, raw_hit_2;

  assign mem_stall    = MemReqM && !MemReadyM;
  assign ld_stall     = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
  assign raw_hit_1    = (RegWriteE && (WA3E == RA1D)) || (RegWriteM && (WA3M == RA1D)) ||
                        (RegWriteW && (WA3W == RA1D));
  assign raw_hit_2    = (RegWriteE && (WA3E == RA2D)) || (RegWriteM && (WA3M == RA2D)) ||
                        (RegWriteW && (WA3W == RA2D));
  // Without forwarding paths, any in-flight producer of a Decode source must drain first
  assign raw_stall    = (FWD_EN == 0) && (raw_hit_1 || raw_hit_2);
  assign PCWrPendingF = PCWriteD || pcw_e_q || pcw_m_q;
  assign MemErr       = mem_err_q;

  // Operand forwarding; the PC index is never bypassed from a later stage
  // NOTE: every output of a combinational block gets a default first, so no path leaves it holding (no latch).
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (FWD_EN != 0) begin
      if (RA1E != PC_REG)
        ForwardAE = fwd_pick(RegWriteM && (WA3M == RA1E), RegWriteW && (WA3W == RA1E));
      if (RA2E != PC_REG)
        ForwardBE = fwd_pick(RegWriteM && (WA3M == RA2E), RegWriteW && (WA3W == RA2E));
    end
  end

  // Stall/flush priority: memory wait, then taken branch, then load/RAW/PC-write hazards.
  // A taken branch seen during a memory wait stays in the held Execute stage and
  // takes effect on the first cycle after the wait releases.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (BranchTakenE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = ld_stall || raw_stall || PCWrPendingF;
      StallD = ld_stall || raw_stall;
      FlushE = ld_stall || raw_stall;
      FlushD = PCWrPendingF || pcw_w_q;
    end
  end

  // Track a PC-writing instruction through Execute, Memory and Writeback
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcw_e_q <= 1'b0;
      pcw_m_q <= 1'b0;
      pcw_w_q <= 1'b0;
    end else begin
      if (FlushE)       pcw_e_q <= 1'b0;
      else if (!StallE) pcw_e_q <= PCWriteD;
      if (!StallM)      pcw_m_q <= pcw_e_q;
      pcw_w_q <= FlushW ? 1'b0 : pcw_m_q;
    end
  end

  // Memory-wait next state and wait-cycle count (saturates at TIMEOUT)
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    if (state_q == S_RUN) begin
      if (mem_stall) state_d = S_WAIT;
    end else if (MemReadyM) begin
      state_d = S_RUN;
    end else begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  // Memory-wait state, counter, and sticky timeout flag; the timeout does not release the stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if ((state_q == S_WAIT) && !MemReadyM && (wait_cnt_d == WAIT_MAX)) mem_err_q <= 1'b1;
    end
  end

  sat_counter #(.W(CNTW)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clear (CntClear),
    .en    (StallF),
    .count (StallCnt)
  );

  sat_counter #(.W(CNTW)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clear (CntClear),
    .en    (FlushE),
    .count (FlushCnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus random stimulus against a behavioural
// model, on two instances (forwarding with 16-bit counters, stall-only with 4-bit counters).
module tb_hazard_ctrl;

  localparam int N   = 2;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCWriteD, BranchTakenE;
  logic       MemReqM, MemReadyM, CntClear;

  logic [1:0]  fa0, fb0, fa1, fb1;
  logic        sf0, sd0, se0, sm0, fd0, fe0, fw0, pp0, me0;
  logic        sf1, sd1, se1, sm1, fd1, fe1, fw1, pp1, me1;
  logic [15:0] sc0, fc0;
  logic [3:0]  sc1, fc1;

  int checks   = 0;
  int failures = 0;
  int base;

  always #5 clk = ~clk;

  hazard_ctrl #(.REGW(4), .CNTW(16), .FWD_EN(1), .TIMEOUT(TMO)) u_fwd (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCWriteD(PCWriteD), .BranchTakenE(BranchTakenE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .CntClear(CntClear),
    .ForwardAE(fa0), .ForwardBE(fb0),
    .StallF(sf0), .StallD(sd0), .StallE(se0), .StallM(sm0),
    .FlushD(fd0), .FlushE(fe0), .FlushW(fw0),
    .PCWrPendingF(pp0), .MemErr(me0), .StallCnt(sc0), .FlushCnt(fc0)
  );

  hazard_ctrl #(.REGW(4), .CNTW(4), .FWD_EN(0), .TIMEOUT(TMO)) u_stall (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCWriteD(PCWriteD), .BranchTakenE(BranchTakenE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .CntClear(CntClear),
    .ForwardAE(fa1), .ForwardBE(fb1),
    .StallF(sf1), .StallD(sd1), .StallE(se1), .StallM(sm1),
    .FlushD(fd1), .FlushE(fe1), .FlushW(fw1),
    .PCWrPendingF(pp1), .MemErr(me1), .StallCnt(sc1), .FlushCnt(fc1)
  );

  // ---------------- behavioural model ----------------
  bit       m_fwd  [N] = '{1'b1, 1'b0};
  int       m_cmax [N] = '{65535, 15};
  bit [2:0] m_pcw  [N];  // bit 0/1/2: a PC-writing instruction sits in E/M/W
  bit       m_waiting [N];
  int       m_waited  [N];
  bit       m_err [N];
  int       m_sc  [N];
  int       m_fc  [N];
  int       e_fa [N], e_fb [N];
  bit       e_sf [N], e_sd [N], e_se [N], e_sm [N], e_fd [N], e_fe [N], e_fw [N], e_pp [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pcw[i] = '0; m_waiting[i] = 0; m_waited[i] = 0;
      m_err[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask

  function automatic int ref_fwd(input int i, input logic [3:0] ra);
    if (!m_fwd[i] || ra == 4'hF) return 0;
    if (RegWriteM && WA3M == ra) return 2;
    if (RegWriteW && WA3W == ra) return 1;
    return 0;
  endfunction

  function automatic bit in_flight(input logic [3:0] r);
    return (RegWriteE && WA3E == r) || (RegWriteM && WA3M == r) || (RegWriteW && WA3W == r);
  endfunction

  task automatic model_eval();
    bit mem, ld, raw, pend;
    for (int i = 0; i < N; i++) begin
      mem  = MemReqM && !MemReadyM;
      ld   = MemtoRegE && (WA3E == RA1D || WA3E == RA2D);
      raw  = !m_fwd[i] && (in_flight(RA1D) || in_flight(RA2D));
      pend = PCWriteD || m_pcw[i][0] || m_pcw[i][1];
      e_fa[i] = ref_fwd(i, RA1E);
      e_fb[i] = ref_fwd(i, RA2E);
      e_pp[i] = pend;
      if (mem) begin
        e_sf[i] = 1; e_sd[i] = 1; e_se[i] = 1; e_sm[i] = 1;
        e_fd[i] = 0; e_fe[i] = 0; e_fw[i] = 1;
      end else if (BranchTakenE) begin
        e_sf[i] = 0; e_sd[i] = 0; e_se[i] = 0; e_sm[i] = 0;
        e_fd[i] = 1; e_fe[i] = 1; e_fw[i] = 0;
      end else begin
        e_sf[i] = ld || raw || pend; e_sd[i] = ld || raw;
        e_se[i] = 0; e_sm[i] = 0; e_fw[i] = 0;
        e_fe[i] = ld || raw; e_fd[i] = pend || m_pcw[i][2];
      end
    end
  endtask

  task automatic model_advance();
    bit [2:0] nxt;
    for (int i = 0; i < N; i++) begin
      if (!reset) begin
        m_pcw[i] = '0; m_waiting[i] = 0; m_waited[i] = 0;
        m_err[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
      end else begin
        nxt[0] = e_fe[i] ? 1'b0 : (e_se[i] ? m_pcw[i][0] : PCWriteD);
        nxt[1] = e_sm[i] ? m_pcw[i][1] : m_pcw[i][0];
        nxt[2] = e_fw[i] ? 1'b0 : m_pcw[i][1];
        m_pcw[i] = nxt;
        if (!m_waiting[i]) begin
          m_waiting[i] = MemReqM && !MemReadyM;
          m_waited[i]  = 0;
        end else if (MemReadyM) begin
          m_waiting[i] = 0;
          m_waited[i]  = 0;
        end else begin
          if (m_waited[i] < TMO) m_waited[i]++;
          if (m_waited[i] == TMO) m_err[i] = 1;
        end
        if (CntClear) begin
          m_sc[i] = 0; m_fc[i] = 0;
        end else begin
          if (e_sf[i] && m_sc[i] < m_cmax[i]) m_sc[i]++;
          if (e_fe[i] && m_fc[i] < m_cmax[i]) m_fc[i]++;
        end
      end
    end
  endtask

  task automatic check_inst(input int i, input logic [1:0] fa, input logic [1:0] fb,
                            input logic sf, input logic sd, input logic se, input logic sm,
                            input logic fd, input logic fe, input logic fw, input logic pp,
                            input logic me, input logic [15:0] sc, input logic [15:0] fc);
    check($sformatf("u%0d.ForwardAE", i), fa, e_fa[i]);
    check($sformatf("u%0d.ForwardBE", i), fb, e_fb[i]);
    check($sformatf("u%0d.StallF", i), sf, e_sf[i]);
    check($sformatf("u%0d.StallD", i), sd, e_sd[i]);
    check($sformatf("u%0d.StallE", i), se, e_se[i]);
    check($sformatf("u%0d.StallM", i), sm, e_sm[i]);
    check($sformatf("u%0d.FlushD", i), fd, e_fd[i]);
    check($sformatf("u%0d.FlushE", i), fe, e_fe[i]);
    check($sformatf("u%0d.FlushW", i), fw, e_fw[i]);
    check($sformatf("u%0d.PCWrPendingF", i), pp, e_pp[i]);
    check($sformatf("u%0d.MemErr", i), me, m_err[i]);
    check($sformatf("u%0d.StallCnt", i), sc, m_sc[i]);
    check($sformatf("u%0d.FlushCnt", i), fc, m_fc[i]);
  endtask

  // Compare both instances at the falling edge, then advance the model past the rising edge
  task automatic cycle();
    @(negedge clk);
    model_eval();
    check_inst(0, fa0, fb0, sf0, sd0, se0, sm0, fd0, fe0, fw0, pp0, me0, sc0, fc0);
    check_inst(1, fa1, fb1, sf1, sd1, se1, sm1, fd1, fe1, fw1, pp1, me1,
               {12'b0, sc1}, {12'b0, fc1});
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0; WA3E = '0; WA3M = '0; WA3W = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; PCWriteD = 0;
    BranchTakenE = 0; MemReqM = 0; MemReadyM = 0; CntClear = 0;
  endtask

  function automatic logic [3:0] rnd_reg();
    if ($urandom_range(0, 7) == 0) return 4'hF;
    return 4'($urandom_range(0, 3));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    reset = 0;
    idle();
    model_reset();
    #2;
    check("rst.MemErr", me0, 1'b0);
    check("rst.StallCnt", sc0, 16'd0);
    check("rst.FlushCnt", fc0, 16'd0);
    check("rst.PCWrPendingF", pp0, 1'b0);
    cycle();
    cycle();
    reset = 1;

    // Forwarding priority and the PC index
    RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3; RA2E = 3; #1;
    check("fwd.m_prio_A", fa0, 2'b10);
    check("fwd.m_prio_B", fb0, 2'b10);
    check("fwd.disabled_A", fa1, 2'b00);
    cycle();
    RegWriteM = 0; #1;
    check("fwd.w_A", fa0, 2'b01);
    cycle();
    RegWriteM = 1; WA3M = 15; WA3W = 15; RA1E = 15; RA2E = 7; #1;
    check("fwd.pc_A", fa0, 2'b00);
    check("fwd.pc_B", fb0, 2'b00);
    cycle();
    idle();

    // Load-use stall, then branch override
    MemtoRegE = 1; WA3E = 5; RA2D = 5; #1;
    check("ld.stalls", {sf0, sd0, fe0, fd0}, 4'b1110);
    cycle();
    MemtoRegE = 0; #1;
    check("ld.released", {sf0, sd0, fe0}, 3'b000);
    cycle();
    MemtoRegE = 1; BranchTakenE = 1; #1;
    check("ld.branch_override", {sf0, sd0, fd0, fe0}, 4'b0011);
    cycle();
    idle();

    // PC write pulse: pending for 3 cycles, FlushD for 4
    PCWriteD = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("pcw.pending_%0d", k), pp0, (k < 3));
      check($sformatf("pcw.flushD_%0d", k), fd0, (k < 4));
      cycle();
      PCWriteD = 0;
    end

    // Memory wait of 3 cycles
    base = m_sc[0];
    MemReqM = 1; MemReadyM = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("mem.hold_%0d", k), {sf0, sd0, se0, sm0, fw0, fd0, fe0}, 7'b1111100);
      cycle();
    end
    MemReadyM = 1; #1;
    check("mem.stallcnt_plus3", sc0, base + 3);
    check("mem.released", {sf0, sd0, se0, sm0, fw0}, 5'b00000);
    cycle();
    idle(); #1;
    check("mem.normal", {sf0, se0, fw0, me0}, 4'b0000);
    cycle();

    // Branch held through a memory wait, acted on after release
    MemReqM = 1; MemReadyM = 0; BranchTakenE = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("mem.branch_held_%0d", k), {fd0, fe0}, 2'b00);
      cycle();
    end
    MemReadyM = 1; #1;
    check("mem.branch_release", {fd0, fe0, sf0}, 3'b110);
    cycle();
    idle();

    // Timeout: MemErr on the 5th WAIT cycle, sticky after ready
    MemReqM = 1; MemReadyM = 0;
    for (int k = 0; k < 7; k++) begin
      #1;
      check($sformatf("tmo.err_%0d", k), me0, (k >= 5));
      cycle();
    end
    MemReadyM = 1; #1;
    check("tmo.err_ready", me0, 1'b1);
    cycle();
    idle(); #1;
    check("tmo.err_sticky", me0, 1'b1);
    reset = 0; #1;
    model_reset();
    check("tmo.rst_err", me0, 1'b0);
    check("tmo.rst_stallcnt", sc0, 16'd0);
    check("tmo.rst_flushcnt", fc0, 16'd0);
    cycle();
    reset = 1;

    // Reset in the middle of WAIT drops the pending PC write
    PCWriteD = 1; #1;
    cycle();
    PCWriteD = 0; MemReqM = 1; MemReadyM = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("wait.pending_held_%0d", k), pp0, 1'b1);
      cycle();
    end
    reset = 0; #1;
    model_reset();
    check("wait.rst_pending", pp0, 1'b0);
    idle();
    cycle();
    reset = 1; #1;
    check("wait.rst_run", {sf0, se0, fw0}, 3'b000);
    MemReqM = 1; MemReadyM = 1; #1;
    check("wait.ready_no_stall", {sf0, se0, fw0}, 3'b000);
    cycle();
    idle();

    // Stall-only mode: RAW stall, saturating counter, clear
    RegWriteW = 1; WA3W = 2; RA1D = 2; RA1E = 2; #1;
    check("raw.stallD", sd1, 1'b1);
    check("raw.fwdA_off", fa1, 2'b00);
    check("raw.fwd_inst_no_stall", sd0, 1'b0);
    check("raw.fwd_inst_fwdA", fa0, 2'b01);
    for (int k = 0; k < 18; k++) cycle();
    check("raw.stallcnt_sat", sc1, 4'hF);
    CntClear = 1;
    cycle();
    CntClear = 0;
    check("clr.stallcnt", sc1, 4'h0);
    check("clr.flushcnt", fc1, 4'h0);
    check("clr.fwd_stallcnt", sc0, 16'd0);
    cycle();
    check("clr.restart", sc1, 4'h1);
    idle();

    // Random stimulus against the model
    for (int n = 0; n < 400; n++) begin
      RA1D = rnd_reg(); RA2D = rnd_reg(); RA1E = rnd_reg(); RA2E = rnd_reg();
      WA3E = rnd_reg(); WA3M = rnd_reg(); WA3W = rnd_reg();
      RegWriteE    = 1'($urandom_range(0, 1));
      RegWriteM    = 1'($urandom_range(0, 1));
      RegWriteW    = 1'($urandom_range(0, 1));
      MemtoRegE    = ($urandom_range(0, 3) == 0);
      PCWriteD     = ($urandom_range(0, 7) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      MemReqM      = ($urandom_range(0, 3) == 0);
      MemReadyM    = ($urandom_range(0, 2) != 0);
      CntClear     = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
